// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
//
// Run controller for the Gameboy CPU core. Holds the CPU in reset, releases
// it for a run, loads IE at the first run cycle, injects an IF value on a
// programmed cycle, and stops on halt or a cycle limit. Accumulates a
// rotate/xor signature over CPU memory writes.
//
// Optional feature macro: CPU_RUN_TRACE_EN
//   defined   -> circular instruction-trace buffer of TRACE_DEPTH bytes
//   undefined -> no buffer; trace_data and trace_fill are constant 0
//
// Ports
//   clock, reset            system clock, async active-low reset
//   start                   one-cycle run request (honoured in IDLE/DONE)
//   timeout, irq_at,
//   irq_vec, ie_vec         run configuration, latched on start
//   cpu_halt, cpu_mem_we,
//   cpu_addr, cpu_data      CPU status and write bus observation
//   cpu_instr, instr_valid  instruction fetch observation (trace)
//   cpu_reset               active-high CPU reset
//   IF_in/IF_load,
//   IE_in/IE_load           interrupt register load strobes and values
//   busy, done, timed_out   run status
//   cycles                  RUN cycles elapsed (saturating)
//   wr_sig, wr_count        write signature and write count
//   trace_idx/trace_data    trace read port (0 = newest), combinational
//   trace_fill              number of valid trace entries
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no run; CPU held in reset
// HOLD  | CPU reset asserted for RST_CYCLES cycles
// RUN   | CPU running; cycle counting, interrupt injection
// DRAIN | one extra cycle so a final write after halt is captured
// DONE  | results held until next start

module cpu_run_ctrl #(
    parameter int CNT_W       = 32,
    parameter int RST_CYCLES  = 2,
    parameter int TRACE_DEPTH = 16,
    localparam int IDX_W      = $clog2(TRACE_DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [CNT_W-1:0]   timeout,
    input  logic [CNT_W-1:0]   irq_at,
    input  logic [4:0]         irq_vec,
    input  logic [4:0]         ie_vec,
    input  logic               cpu_halt,
    input  logic               cpu_mem_we,
    input  logic [15:0]        cpu_addr,
    input  logic [7:0]         cpu_data,
    input  logic [7:0]         cpu_instr,
    input  logic               instr_valid,
    output logic               cpu_reset,
    output logic [4:0]         IF_in,
    output logic [4:0]         IE_in,
    output logic               IF_load,
    output logic               IE_load,
    output logic               busy,
    output logic               done,
    output logic               timed_out,
    output logic [CNT_W-1:0]   cycles,
    output logic [15:0]        wr_sig,
    output logic [15:0]        wr_count,
    input  logic [IDX_W-1:0]   trace_idx,
    output logic [7:0]         trace_data,
    output logic [IDX_W:0]     trace_fill
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    state_t             nxt;
    logic               limit_hit;
    logic               start_run;
    logic               if_fire;
    logic               if_fired;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [CNT_W-1:0]   timeout_q;
    logic [CNT_W-1:0]   irq_at_q;
    logic [4:0]         irq_vec_q;
    logic [4:0]         ie_vec_q;
    logic [CNT_W-1:0]   cycles_inc;

    assign start_run  = start && (state == S_IDLE || state == S_DONE);
    assign cycles_inc = (cycles == '1) ? cycles : cycles + CNT_W'(1);

    // IF strobe is registered, so it is raised on the edge into the cycle
    // whose index equals irq_at.
    assign if_fire = (state == S_RUN) && (nxt == S_RUN) && !if_fired &&
                     (irq_at_q != '0) && (cycles_inc == irq_at_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt       = state;
        limit_hit = 1'b0;
        case (state)
            S_IDLE, S_DONE: if (start) nxt = S_HOLD;
            S_HOLD:         if (hold_cnt == '0) nxt = S_RUN;
            S_RUN: begin
                if (cpu_halt) begin
                    nxt = S_DRAIN;
                end else if (timeout_q != '0 && cycles == timeout_q - CNT_W'(1)) begin
                    nxt       = S_DONE;
                    limit_hit = 1'b1;
                end
            end
            S_DRAIN:        nxt = S_DONE;
            default:        nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            IE_load   <= 1'b0;
            IE_in     <= 5'h00;
            IF_load   <= 1'b0;
            IF_in     <= 5'h00;
            if_fired  <= 1'b0;
            hold_cnt  <= '0;
            timeout_q <= '0;
            irq_at_q  <= '0;
            irq_vec_q <= 5'h00;
            ie_vec_q  <= 5'h00;
            cycles    <= '0;
            timed_out <= 1'b0;
            wr_sig    <= 16'h0000;
            wr_count  <= 16'h0000;
        end else begin
            cpu_reset <= (nxt == S_IDLE) || (nxt == S_HOLD);
            busy      <= (nxt == S_HOLD) || (nxt == S_RUN) || (nxt == S_DRAIN);
            done      <= (nxt == S_DONE);

            IE_load   <= (state == S_HOLD) && (nxt == S_RUN);
            IE_in     <= ((state == S_HOLD) && (nxt == S_RUN)) ? ie_vec_q : 5'h00;
            IF_load   <= if_fire;
            IF_in     <= if_fire ? irq_vec_q : 5'h00;

            if (start_run) begin
                hold_cnt  <= HOLD_W'(RST_CYCLES - 1);
                timeout_q <= timeout;
                irq_at_q  <= irq_at;
                irq_vec_q <= irq_vec;
                ie_vec_q  <= ie_vec;
                cycles    <= '0;
                timed_out <= 1'b0;
                wr_sig    <= 16'h0000;
                wr_count  <= 16'h0000;
                if_fired  <= 1'b0;
            end else begin
                if (state == S_HOLD && hold_cnt != '0)
                    hold_cnt <= hold_cnt - HOLD_W'(1);
                if (state == S_RUN)
                    cycles <= cycles_inc;
                if (limit_hit)
                    timed_out <= 1'b1;
                if (if_fire)
                    if_fired <= 1'b1;
                if ((state == S_RUN || state == S_DRAIN) && cpu_mem_we) begin
                    wr_sig <= {wr_sig[14:0], wr_sig[15]} ^ cpu_addr ^ {8'h00, cpu_data};
                    if (wr_count != 16'hFFFF)
                        wr_count <= wr_count + 16'h0001;
                end
            end
        end
    end

`ifdef CPU_RUN_TRACE_EN
    logic [7:0]       trace_mem [TRACE_DEPTH];
    logic [IDX_W-1:0] trace_wp;
    logic [IDX_W:0]   fill_q;
    logic [IDX_W-1:0] rd_addr;

    // Storage needs no reset; validity is tracked by fill_q.
    always_ff @(posedge clock) begin
        if (state == S_RUN && instr_valid)
            trace_mem[trace_wp] <= cpu_instr;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trace_wp <= '0;
            fill_q   <= '0;
        end else if (start_run) begin
            trace_wp <= '0;
            fill_q   <= '0;
        end else if (state == S_RUN && instr_valid) begin
            trace_wp <= trace_wp + IDX_W'(1);
            if (fill_q != (IDX_W+1)'(TRACE_DEPTH))
                fill_q <= fill_q + (IDX_W+1)'(1);
        end
    end

    // Index 0 is the entry just behind the write pointer; wraps modulo depth.
    assign rd_addr    = trace_wp - IDX_W'(1) - trace_idx;
    assign trace_data = ({1'b0, trace_idx} < fill_q) ? trace_mem[rd_addr] : 8'h00;
    assign trace_fill = fill_q;
`else
    logic trace_unused;
    assign trace_unused = ^{cpu_instr, instr_valid, trace_idx};
    assign trace_data   = 8'h00;
    assign trace_fill   = '0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

    localparam int CNT_W = 32;
    localparam int IDX_W = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [CNT_W-1:0]  timeout;
    logic [CNT_W-1:0]  irq_at;
    logic [4:0]        irq_vec;
    logic [4:0]        ie_vec;
    logic              cpu_halt;
    logic              cpu_mem_we;
    logic [15:0]       cpu_addr;
    logic [7:0]        cpu_data;
    logic [7:0]        cpu_instr;
    logic              instr_valid;
    logic              cpu_reset;
    logic [4:0]        IF_in;
    logic [4:0]        IE_in;
    logic              IF_load;
    logic              IE_load;
    logic              busy;
    logic              done;
    logic              timed_out;
    logic [CNT_W-1:0]  cycles;
    logic [15:0]       wr_sig;
    logic [15:0]       wr_count;
    logic [IDX_W-1:0]  trace_idx;
    logic [7:0]        trace_data;
    logic [IDX_W:0]    trace_fill;

    int checks = 0;
    int errors = 0;
    int n;

    cpu_run_ctrl #(.CNT_W(CNT_W), .RST_CYCLES(2), .TRACE_DEPTH(16)) dut (
        .clock(clock), .reset(reset), .start(start), .timeout(timeout),
        .irq_at(irq_at), .irq_vec(irq_vec), .ie_vec(ie_vec),
        .cpu_halt(cpu_halt), .cpu_mem_we(cpu_mem_we), .cpu_addr(cpu_addr),
        .cpu_data(cpu_data), .cpu_instr(cpu_instr), .instr_valid(instr_valid),
        .cpu_reset(cpu_reset), .IF_in(IF_in), .IE_in(IE_in),
        .IF_load(IF_load), .IE_load(IE_load), .busy(busy), .done(done),
        .timed_out(timed_out), .cycles(cycles), .wr_sig(wr_sig),
        .wr_count(wr_count), .trace_idx(trace_idx), .trace_data(trace_data),
        .trace_fill(trace_fill)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Leaves the bench positioned in RUN cycle 0 (start edge + 2 HOLD cycles).
    task automatic start_run(input logic [31:0] to, input logic [31:0] ia,
                             input logic [4:0] iv, input logic [4:0] ev);
        timeout = to; irq_at = ia; irq_vec = iv; ie_vec = ev;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("hold_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; timeout = '0; irq_at = '0; irq_vec = '0;
        ie_vec = '0; cpu_halt = 1'b0; cpu_mem_we = 1'b0; cpu_addr = '0;
        cpu_data = '0; cpu_instr = '0; instr_valid = 1'b0; trace_idx = '0;
        #12;
        check("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_cycles", cycles, 32'd0);
        check("rst_wr_sig", {16'b0, wr_sig}, 32'd0);
        check("rst_fill", {27'b0, trace_fill}, 32'd0);
        reset = 1'b1;
        tick();
        check("idle_cpu_reset", {31'b0, cpu_reset}, 32'd1);

        // Run A: halt at RUN cycle 40, IE at cycle 0, IF at cycle 10, writes.
        start_run(32'd0, 32'd10, 5'h04, 5'h1F);
        check("run_cpu_reset", {31'b0, cpu_reset}, 32'd0);
        check("run_busy", {31'b0, busy}, 32'd1);
        for (int c = 0; c < 40; c++) begin
            check("ie_load", {31'b0, IE_load}, (c == 0) ? 32'd1 : 32'd0);
            check("ie_in", {27'b0, IE_in}, (c == 0) ? 32'h1F : 32'h0);
            check("if_load", {31'b0, IF_load}, (c == 10) ? 32'd1 : 32'd0);
            check("if_in", {27'b0, IF_in}, (c == 10) ? 32'h04 : 32'h0);
            check("cycles_run", cycles, c);
            cpu_mem_we = (c == 5 || c == 6);
            cpu_addr   = (c == 5) ? 16'hC000 : 16'hC001;
            cpu_data   = (c == 5) ? 8'h12 : 8'h34;
            tick();
        end
        // C000^0012 = C012; rotl(C012)=8025 ^ C001 ^ 0034 = 4010
        check("wr_count_2", {16'b0, wr_count}, 32'd2);
        check("wr_sig_2", {16'b0, wr_sig}, 32'h4010);
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        check("drain_busy", {31'b0, busy}, 32'd1);
        check("drain_done", {31'b0, done}, 32'd0);
        check("drain_cycles", cycles, 32'd41);
        cpu_mem_we = 1'b1; cpu_addr = 16'hA000; cpu_data = 8'h55;
        tick();
        cpu_mem_we = 1'b0;
        // rotl(4010)=8020 ^ A000 ^ 0055 = 2075
        check("halt_done", {31'b0, done}, 32'd1);
        check("halt_busy", {31'b0, busy}, 32'd0);
        check("halt_cycles", cycles, 32'd41);
        check("halt_timed_out", {31'b0, timed_out}, 32'd0);
        check("drain_wr_count", {16'b0, wr_count}, 32'd3);
        check("drain_wr_sig", {16'b0, wr_sig}, 32'h2075);

        // Run B: limit of 100; a start pulse mid-run must be ignored.
        start_run(32'd100, 32'd0, 5'h00, 5'h00);
        check("restart_wr_count", {16'b0, wr_count}, 32'd0);
        n = 0;
        while (!done && n < 300) begin
            start = (n == 50);
            tick();
            n++;
        end
        start = 1'b0;
        check("limit_latency", n, 32'd100);
        check("limit_cycles", cycles, 32'd100);
        check("limit_timed_out", {31'b0, timed_out}, 32'd1);

        // Run C: unlimited; 20 fetches into the trace, then halt.
        start_run(32'd0, 32'd0, 5'h00, 5'h00);
        check("restart_timed_out", {31'b0, timed_out}, 32'd0);
        for (int c = 0; c < 300; c++) begin
            instr_valid = (c < 20);
            cpu_instr   = 8'(c);
            tick();
        end
        instr_valid = 1'b0;
        check("unlim_busy", {31'b0, busy}, 32'd1);
        check("unlim_done", {31'b0, done}, 32'd0);
        check("unlim_cycles", cycles, 32'd300);
`ifdef CPU_RUN_TRACE_EN
        check("trace_fill", {27'b0, trace_fill}, 32'd16);
        trace_idx = 4'd0; #1;
        check("trace_newest", {24'b0, trace_data}, 32'h13);
        trace_idx = 4'd15; #1;
        check("trace_oldest", {24'b0, trace_data}, 32'h04);
`else
        check("trace_fill_off", {27'b0, trace_fill}, 32'd0);
        trace_idx = 4'd3; #1;
        check("trace_data_off", {24'b0, trace_data}, 32'd0);
`endif
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        tick();
        check("unlim_halt_done", {31'b0, done}, 32'd1);
        check("unlim_halt_cycles", cycles, 32'd301);

        // Run D: reset mid-RUN, then a clean limited run.
        start_run(32'd0, 32'd0, 5'h00, 5'h1F);
        cpu_mem_we = 1'b1; cpu_addr = 16'h1234; cpu_data = 8'h56;
        repeat (5) tick();
        cpu_mem_we = 1'b0;
        reset = 1'b0;
        #1;
        check("abort_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_cycles", cycles, 32'd0);
        check("abort_wr_count", {16'b0, wr_count}, 32'd0);
        check("abort_fill", {27'b0, trace_fill}, 32'd0);
        #10;
        reset = 1'b1;
        tick();
        start_run(32'd5, 32'd0, 5'h00, 5'h00);
        n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        check("clean_latency", n, 32'd5);
        check("clean_cycles", cycles, 32'd5);
        check("clean_timed_out", {31'b0, timed_out}, 32'd1);
        check("clean_wr_count", {16'b0, wr_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
